// File: rtl/tfpga_uart_pkg.sv
// Shared types and constants for the TinyFPGA-BX UART receive path.
package tfpga_uart_pkg;

  // Payload width of one 8N1 character.
  localparam int unsigned DATA_BITS = 8;

  // Receiver frame states.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } uart_rx_state_e;

  // System clocks per bit period, truncated.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/tfpga_sync_2ff.sv
// Generic 1-bit two-flop synchronizer with a configurable reset value.
module tfpga_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second filters it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/tfpga_uart_rx.sv
// 8N1 UART receiver: oversampled rx pin, one-entry valid/ready output buffer,
// framing-error and overrun pulses.
module tfpga_uart_rx
  import tfpga_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 128000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW         = 3;

  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  // Below four clocks per bit the mid-bit sampling has no margin at all.
  if (CLKS_PER_BIT < 4) begin : g_bad_cfg
    $error("tfpga_uart_rx: CLK_HZ/BAUD must be at least 4");
  end

  logic rxs;

  tfpga_sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync_rx (
    .clk_i(sys_clk),
    .rst_i(sys_rst),
    .d_i  (rx),
    .q_o  (rxs)
  );

  uart_rx_state_e       state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 deliver;

  // Frame state, bit timing and assembled byte.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Frame sequencing: find the start edge, sample each bit at mid-period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end

      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          idx_d = '0;
          // A start bit that is high again by mid-bit was only a glitch.
          state_d = rxs ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d = '0;
          if (rxs) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StWaitHigh: begin
        // A held-low break yields a single frame error, not one per bit time.
        if (rxs) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // One-entry output buffer: load, drain on handshake, or flag an overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;

    if (deliver) begin
      // A byte accepted this very cycle frees the slot for the new one.
      if (!valid_q || rx_ready) begin
        data_d  = shift_q_next();
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  // The last data bit lands in shift_q well before the stop sample.
  function automatic logic [DATA_BITS-1:0] shift_q_next();
    return shift_q;
  endfunction

  // Output buffer and status pulse registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;

endmodule
